// File: rtl/seq_code_lock.sv
// rtl/seq_code_lock.sv - serial code lock with open timeout, failed-attempt lockout and in-field code change
module seq_code_lock #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE_DEFAULT   = 4'b1011,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  OPEN_TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key,
  input  logic                           key_valid,
  input  logic                           attempt_clr,
  input  logic                           relock,
  input  logic                           prog_valid,
  input  logic [CODE_LEN-1:0]            prog_code,
  output logic                           unlocked,
  output logic                           unlock_pulse,
  output logic                           fail_pulse,
  output logic                           alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int BW   = $clog2(CODE_LEN);
  localparam int TMAX = (OPEN_TIMEOUT > LOCKOUT_CYCLES) ? OPEN_TIMEOUT : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [TW-1:0] OPEN_LAST = TW'((OPEN_TIMEOUT > 0) ? OPEN_TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam bit            OPEN_TIMED = (OPEN_TIMEOUT != 0);

  // The unused fourth encoding is treated as illegal and recovers to LOCKED.
  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                unlocked_q, unlocked_d;
  logic                unlock_pulse_q, unlock_pulse_d;
  logic                fail_pulse_q, fail_pulse_d;
  logic                alarm_q, alarm_d;

  logic [CODE_LEN-1:0] attempt;
  logic [FW-1:0]       fail_next;
  logic [TW-1:0]       timer_inc;

  // Candidate attempt value, saturated fail count and saturated timer increment.
  always_comb begin
    attempt   = {shift_q[CODE_LEN-2:0], key};
    fail_next = (fail_cnt_q >= FAIL_MAX) ? FAIL_MAX : fail_cnt_q + FW'(1);
    timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
  end

  // Next-state logic: attempt assembly, compare, timers and code programming.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    code_d         = code_q;
    fail_cnt_d     = fail_cnt_q;
    timer_d        = timer_q;
    unlock_pulse_d = 1'b0;
    fail_pulse_d   = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        timer_d = '0;
        if (attempt_clr) begin
          // A clear in the same cycle as a strobe drops the strobed bit.
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (key_valid) begin
          shift_d = attempt;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (attempt == code_q) begin
              state_d        = ST_OPEN;
              fail_cnt_d     = '0;
              unlock_pulse_d = 1'b1;
            end else begin
              fail_pulse_d = 1'b1;
              fail_cnt_d   = fail_next;
              if (fail_next == FAIL_MAX) begin
                state_d = ST_LOCKOUT;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      ST_OPEN: begin
        // A code write is honoured even when relock or timeout fires this cycle.
        if (prog_valid) begin
          code_d = prog_code;
        end
        if (relock || (OPEN_TIMED && (timer_q == OPEN_LAST))) begin
          state_d   = ST_LOCKED;
          bit_cnt_d = '0;
          shift_d   = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q >= LOCK_LAST) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d   = ST_LOCKED;
        bit_cnt_d = '0;
        shift_d   = '0;
        timer_d   = '0;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_LOCKOUT);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_LOCKED;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      code_q         <= CODE_DEFAULT;
      fail_cnt_q     <= '0;
      timer_q        <= '0;
      unlocked_q     <= 1'b0;
      unlock_pulse_q <= 1'b0;
      fail_pulse_q   <= 1'b0;
      alarm_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      code_q         <= code_d;
      fail_cnt_q     <= fail_cnt_d;
      timer_q        <= timer_d;
      unlocked_q     <= unlocked_d;
      unlock_pulse_q <= unlock_pulse_d;
      fail_pulse_q   <= fail_pulse_d;
      alarm_q        <= alarm_d;
    end
  end

  assign unlocked     = unlocked_q;
  assign unlock_pulse = unlock_pulse_q;
  assign fail_pulse   = fail_pulse_q;
  assign alarm        = alarm_q;
  assign fail_cnt     = fail_cnt_q;

endmodule
